// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared sizes and register index constants for the MIPS datapath
//
// Purpose: common widths and architectural register numbers used by the
//          register file and by write-address selection upstream.
// Ports:   none (package).
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Architectural register numbers. REG_RA is the jal link target.
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_AT   = 5'd1;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/mips_reg_word.sv
// rtl/mips_reg_word.sv - one general-purpose register with synchronous reset and load enable
//
// Purpose: storage for a single register-file entry.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high clear; wins over i_load
//   i_load  in   load i_d at the next rising edge
//   i_d     in   [W-1:0] data to load
//   o_q     out  [W-1:0] stored value
module mips_reg_word #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : mips_reg_word

// File: rtl/mips_reg_file.sv
// rtl/mips_reg_file.sv - 32-entry MIPS register file, two combinational reads, one write
//
// Purpose: GPR file feeding ALU operand A (port 1) and operand B / store data
//          (port 2). $0 has no storage and always reads zero.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high clear of all registers
//   rd_addr1  in   [ADDR_W-1:0] rs address
//   rd_addr2  in   [ADDR_W-1:0] rt address
//   wr_en     in   RegWrite
//   wr_addr   in   [ADDR_W-1:0] write-back address
//   wr_data   in   [DATA_W-1:0] write-back data
//   rd_data1  out  [DATA_W-1:0] operand A
//   rd_data2  out  [DATA_W-1:0] operand B / store data
module mips_reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  localparam int DEPTH     = 2 ** ADDR_W;
  // $at is the lowest register that actually has storage.
  localparam int FIRST_REG = int'(REG_AT);

  logic [DATA_W-1:0] w_regs [DEPTH];
  logic              w_wr_live;
  logic              w_byp1;
  logic              w_byp2;

  assign w_regs[0] = '0;

  // A write only takes effect outside reset and never to $0; the same
  // qualifier gates forwarding so a lost write is never forwarded either.
  assign w_wr_live = wr_en && !reset && (wr_addr != '0);

  for (genvar i = FIRST_REG; i < DEPTH; i++) begin : g_word
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);

    mips_reg_word #(.W(DATA_W)) u_word (
      .clk    (clk),
      .reset  (reset),
      .i_load (wr_en && (wr_addr == IDX)),
      .i_d    (wr_data),
      .o_q    (w_regs[i])
    );
  end

  // Forwarding of wr_data is safe only because write-back data never
  // depends on this cycle's read data (guaranteed by control).
  assign w_byp1 = BYPASS && w_wr_live && (wr_addr == rd_addr1);
  assign w_byp2 = BYPASS && w_wr_live && (wr_addr == rd_addr2);

  assign rd_data1 = w_byp1 ? wr_data : w_regs[rd_addr1];
  assign rd_data2 = w_byp2 ? wr_data : w_regs[rd_addr2];

endmodule : mips_reg_file

// File: tb/tb_mips_reg_file.sv
// tb/tb_mips_reg_file.sv - directed self-checking bench for mips_reg_file (bypass and no-bypass)
module tb_mips_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] b_rd1, b_rd2;
  logic [31:0] n_rd1, n_rd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data1(b_rd1), .rd_data2(b_rd2)
  );

  mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nob (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data1(n_rd1), .rd_data2(n_rd2)
  );

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #1;
      checks++;
      if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0 || n_rd1 !== 32'h0 || n_rd2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got b1=%h b2=%h n1=%h n2=%h want 00000000",
                 i, b_rd1, b_rd2, n_rd1, n_rd2);
      end
    end
  endtask

  task automatic test_basic_write();
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0; rd_addr1 = 5'd8; rd_addr2 = 5'd8;
    #1;
    checks++;
    if (b_rd1 !== 32'hDEAD_BEEF || b_rd2 !== 32'hDEAD_BEEF ||
        n_rd1 !== 32'hDEAD_BEEF || n_rd2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_read8 got b1=%h b2=%h n1=%h n2=%h want deadbeef",
               b_rd1, b_rd2, n_rd1, n_rd2);
    end
    rd_addr2 = 5'd9;
    #1;
    checks++;
    if (b_rd2 !== 32'h0 || n_rd2 !== 32'h0) begin
      errors++;
      $display("FAIL basic_read9 got b2=%h n2=%h want 00000000", b_rd2, n_rd2);
    end
  endtask

  task automatic test_zero();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    checks++;
    if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0 || n_rd1 !== 32'h0) begin
      errors++;
      $display("FAIL zero_same_cycle got b1=%h b2=%h n1=%h want 00000000", b_rd1, b_rd2, n_rd1);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (b_rd1 !== 32'h0 || n_rd1 !== 32'h0) begin
      errors++;
      $display("FAIL zero_next_cycle got b1=%h n1=%h want 00000000", b_rd1, n_rd1);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1111_1111;
    tick();
    wr_addr = 5'd6; wr_data = 32'h6666_6666;
    tick();
    wr_addr = 5'd5; wr_data = 32'h2222_2222;
    rd_addr1 = 5'd5; rd_addr2 = 5'd6;
    #1;
    checks++;
    if (b_rd1 !== 32'h2222_2222) begin
      errors++;
      $display("FAIL bypass_port1 got %h want 22222222", b_rd1);
    end
    checks++;
    if (b_rd2 !== 32'h6666_6666 || n_rd2 !== 32'h6666_6666) begin
      errors++;
      $display("FAIL bypass_other_port got b2=%h n2=%h want 66666666", b_rd2, n_rd2);
    end
    checks++;
    if (n_rd1 !== 32'h1111_1111) begin
      errors++;
      $display("FAIL nobypass_old_value got %h want 11111111", n_rd1);
    end
    tick();
    // Both ports forwarding the same write at once.
    wr_addr = 5'd6; wr_data = 32'h7777_0077;
    rd_addr1 = 5'd6; rd_addr2 = 5'd6;
    #1;
    checks++;
    if (b_rd1 !== 32'h7777_0077 || b_rd2 !== 32'h7777_0077) begin
      errors++;
      $display("FAIL bypass_both_ports got b1=%h b2=%h want 77770077", b_rd1, b_rd2);
    end
    checks++;
    if (n_rd1 !== 32'h6666_6666 || n_rd2 !== 32'h6666_6666) begin
      errors++;
      $display("FAIL nobypass_both_ports got n1=%h n2=%h want 66666666", n_rd1, n_rd2);
    end
    tick();
    wr_en = 1'b0; rd_addr1 = 5'd5;
    #1;
    checks++;
    if (b_rd1 !== 32'h2222_2222 || n_rd1 !== 32'h2222_2222 ||
        b_rd2 !== 32'h7777_0077 || n_rd2 !== 32'h7777_0077) begin
      errors++;
      $display("FAIL bypass_committed got b1=%h n1=%h b2=%h n2=%h want 22222222/77770077",
               b_rd1, n_rd1, b_rd2, n_rd2);
    end
  endtask

  task automatic test_reset_beats_write();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h0040_0008;
    tick();
    reset = 1'b1; wr_data = 32'hABCD_0000; rd_addr1 = 5'd31; rd_addr2 = 5'd8;
    #1;
    checks++;
    if (b_rd1 !== 32'h0040_0008 || n_rd1 !== 32'h0040_0008) begin
      errors++;
      $display("FAIL reset_no_bypass got b1=%h n1=%h want 00400008", b_rd1, n_rd1);
    end
    tick();
    reset = 1'b0; wr_en = 1'b0;
    #1;
    checks++;
    if (b_rd1 !== 32'h0 || n_rd1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_beats_write got b1=%h n1=%h want 00000000", b_rd1, n_rd1);
    end
    checks++;
    if (b_rd2 !== 32'h0 || n_rd2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_clears_reg8 got b2=%h n2=%h want 00000000", b_rd2, n_rd2);
    end
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0001;
    rd_addr1 = 5'd7; rd_addr2 = 5'd7;
    tick();
    wr_data = 32'hFFFF_FFFE;
    #1;
    checks++;
    if (n_rd1 !== 32'h0000_0001) begin
      errors++;
      $display("FAIL b2b_nobypass got %h want 00000001", n_rd1);
    end
    checks++;
    if (b_rd1 !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL b2b_bypass got %h want fffffffe", b_rd1);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (b_rd1 !== 32'hFFFF_FFFE || n_rd1 !== 32'hFFFF_FFFE ||
        b_rd2 !== 32'hFFFF_FFFE || n_rd2 !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL b2b_final got b1=%h n1=%h b2=%h n2=%h want fffffffe",
               b_rd1, n_rd1, b_rd2, n_rd2);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    #2;
    test_reset();
    test_basic_write();
    test_zero();
    test_bypass();
    test_reset_beats_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mips_reg_file
